// File: rtl/vram_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_buffer
// Description : Queues CPU pixel writes and drains them into video memory,
//               optionally only during blanking; adds a clear-screen sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_buffer #(
   parameter int DATA_WIDTH = 3,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1024,
   parameter int DEPTH_LOG2 = 3,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    iWriteRequest,
   input  logic [ADDR_WIDTH-1:0]   iWriteAddress,
   input  logic [DATA_WIDTH-1:0]   iWriteData,
   input  logic                    iBlankOnly,
   input  logic [9:0]              iColumnCount,
   input  logic [9:0]              iRowCount,
   input  logic                    iClearRequest,
   input  logic [DATA_WIDTH-1:0]   iClearColor,
   input  logic                    iClearOverflow,
   output logic                    oMemWriteEnable,
   output logic [ADDR_WIDTH-1:0]   oMemWriteAddress,
   output logic [DATA_WIDTH-1:0]   oMemDataIn,
   output logic                    oFull,
   output logic                    oEmpty,
   output logic [DEPTH_LOG2:0]     oCount,
   output logic                    oBusy,
   output logic                    oOverflow
);

   localparam int c_DEPTH   = 2 ** DEPTH_LOG2;
   localparam int c_ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_DRAIN = 2'd1;
   localparam logic [1:0] c_CLEAR = 2'd2;

   localparam logic [9:0]            c_H_ACTIVE   = 10'(H_ACTIVE);
   localparam logic [9:0]            c_V_ACTIVE   = 10'(V_ACTIVE);
   localparam logic [DEPTH_LOG2:0]   c_CNT_FULL   = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0]   c_CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] c_SWEEP_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_nextState;
   logic [c_ENTRY_W-1:0]  r_fifo [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wrPtr;
   logic [DEPTH_LOG2-1:0] r_rdPtr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [ADDR_WIDTH-1:0] r_sweepAddr;
   logic [DATA_WIDTH-1:0] r_clearColor;
   logic                  r_overflow;
   logic                  r_memWe;
   logic [ADDR_WIDTH-1:0] r_memAddr;
   logic [DATA_WIDTH-1:0] r_memData;

   logic w_win;
   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_sweepWrite;
   logic w_startClear;
   logic w_sweepLast;

   assign w_win       = ~iBlankOnly | (iColumnCount >= c_H_ACTIVE) | (iRowCount >= c_V_ACTIVE);
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_CNT_FULL);
   // Full is judged on pre-edge occupancy, so a same-cycle pop never rescues a push.
   assign w_push      = iWriteRequest & ~w_full;
   assign w_sweepLast = (r_sweepAddr == c_SWEEP_LAST);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_state <= c_IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE: begin
            if (iClearRequest)  w_nextState = c_CLEAR;
            else if (~w_empty)  w_nextState = c_DRAIN;
         end
         c_DRAIN: begin
            if (iClearRequest)  w_nextState = c_CLEAR;
            else if (w_empty)   w_nextState = c_IDLE;
         end
         c_CLEAR: begin
            if (w_win & w_sweepLast) w_nextState = w_empty ? c_IDLE : c_DRAIN;
         end
         default: w_nextState = c_IDLE;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_sweepWrite = 1'b0;
      w_startClear = 1'b0;
      oBusy        = 1'b0;
      case (r_state)
         c_IDLE:  w_startClear = iClearRequest;
         c_DRAIN: begin
            w_startClear = iClearRequest;
            w_pop        = w_win & ~w_empty & ~iClearRequest;
         end
         c_CLEAR: begin
            oBusy        = 1'b1;
            w_sweepWrite = w_win;
         end
         default: ;
      endcase
   end

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge Clock) begin
      if (w_push) r_fifo[r_wrPtr] <= {iWriteAddress, iWriteData};
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_sweepAddr  <= '0;
         r_clearColor <= '0;
         r_memWe      <= 1'b0;
         r_memAddr    <= '0;
         r_memData    <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
         if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
         if (w_push & ~w_pop)      r_count <= r_count + c_CNT_ONE;
         else if (~w_push & w_pop) r_count <= r_count - c_CNT_ONE;

         if (iClearOverflow)               r_overflow <= 1'b0;
         else if (iWriteRequest & w_full)  r_overflow <= 1'b1;

         if (w_startClear) begin
            r_clearColor <= iClearColor;
            r_sweepAddr  <= '0;
         end else if (w_sweepWrite) begin
            r_sweepAddr  <= r_sweepAddr + c_ADDR_ONE;
         end

         r_memWe <= w_pop | w_sweepWrite;
         if (w_pop)             {r_memAddr, r_memData} <= r_fifo[r_rdPtr];
         else if (w_sweepWrite) {r_memAddr, r_memData} <= {r_sweepAddr, r_clearColor};
      end
   end

   assign oMemWriteEnable  = r_memWe;
   assign oMemWriteAddress = r_memAddr;
   assign oMemDataIn       = r_memData;
   assign oFull            = w_full;
   assign oEmpty           = w_empty;
   assign oCount           = r_count;
   assign oOverflow        = r_overflow;

endmodule
`default_nettype wire
